// File: rtl/wisc_pkg.sv
// Shared types for the write-back stage: word and register-index widths and
// the write-back FSM state encoding.
package wisc_pkg;
  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int NREG      = 16;

  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {WB_RUN, WB_HALTED} wb_state_t;
endpackage

// File: rtl/rf_array.sv
// Architectural register storage: one synchronous write port, two
// asynchronous read ports, R0 reads as zero and is never written.
module rf_array #(
  parameter int NREG   = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr_a,
  input  logic [IDX_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);
  logic [DATA_W-1:0] r_mem [NREG];

  // Async clear of every entry keeps reads at zero the instant reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result word, commits it to the register file,
// bypasses same-cycle writes to decode reads, and sequences HALT.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RegWrite_in,
  input  logic                          ret_in,
  input  logic                          mem_to_reg_in,
  input  logic [wisc_pkg::REG_IDX_W-1:0] reg_rd_in,
  input  logic [DATA_W-1:0]             mem_read_data_in,
  input  logic [DATA_W-1:0]             alu_result_in,
  input  logic                          HALT_in,
  input  logic [wisc_pkg::REG_IDX_W-1:0] rs_addr,
  input  logic [wisc_pkg::REG_IDX_W-1:0] rt_addr,
  output logic [DATA_W-1:0]             rs_data,
  output logic [DATA_W-1:0]             rt_data,
  output logic                          wb_en_out,
  output logic [wisc_pkg::REG_IDX_W-1:0] wb_rd_out,
  output logic [DATA_W-1:0]             wb_data_out,
  output logic                          ret_commit,
  output logic                          halted,
  output logic [CNT_W-1:0]              wr_count
);
  import wisc_pkg::*;

  wb_state_t         r_state;
  wb_state_t         w_state_next;
  logic              r_ret_commit;
  logic [CNT_W-1:0]  r_wr_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_rf_rs;
  logic [DATA_W-1:0] w_rf_rt;

  assign w_wb_data = mem_to_reg_in ? mem_read_data_in : alu_result_in;
  assign w_commit  = RegWrite_in && (reg_rd_in != '0) && (r_state == WB_RUN);

  rf_array #(
    .NREG   (NREG),
    .DATA_W (DATA_W),
    .IDX_W  (REG_IDX_W)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_commit),
    .i_waddr   (reg_rd_in),
    .i_wdata   (w_wb_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (w_rf_rs),
    .o_rdata_b (w_rf_rt)
  );

  // Write-before-read: a commit this cycle is visible to decode immediately.
  always_comb begin
    rs_data = w_rf_rs;
    rt_data = w_rf_rt;
    if (rs_addr == '0)                          rs_data = '0;
    else if (w_commit && (rs_addr == reg_rd_in)) rs_data = w_wb_data;
    if (rt_addr == '0)                          rt_data = '0;
    else if (w_commit && (rt_addr == reg_rd_in)) rt_data = w_wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WB_RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WB_RUN:    if (HALT_in) w_state_next = WB_HALTED;
      WB_HALTED: w_state_next = WB_HALTED;
      default:   w_state_next = WB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_commit <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      r_ret_commit <= ret_in && (r_state == WB_RUN);
      if (w_commit && (r_wr_count != {CNT_W{1'b1}}))
        r_wr_count <= r_wr_count + CNT_W'(1);
    end
  end

  assign wb_en_out   = w_commit;
  assign wb_rd_out   = reg_rd_in;
  assign wb_data_out = w_wb_data;
  assign ret_commit  = r_ret_commit;
  assign halted      = (r_state == WB_HALTED);
  assign wr_count    = r_wr_count;
endmodule
